// File: rtl/message_stream_combiner_pkg.sv
// Shared definitions for the message stream combiner: header length field
// position helpers and the round-robin index step.
package message_stream_combiner_pkg;

    localparam int MAX_STREAMS = 8;
    localparam int IDX_W       = 3;

    typedef logic [IDX_W-1:0] stream_idx_t;

    // The length field sits just below the header MSB.
    function automatic int msg_len_msb(input int wdth);
        return wdth - 2;
    endfunction

    function automatic int msg_len_lsb(input int wdth, input int len_wdth);
        return wdth - 1 - len_wdth;
    endfunction

    function automatic stream_idx_t rr_next(input stream_idx_t idx, input int n_streams);
        if (int'(idx) >= n_streams - 1) begin
            return '0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module msg_fifo #(
    parameter int WDTH      = 32,
    parameter int LOG_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [WDTH-1:0] data_in,
    output logic [WDTH-1:0] data_out,
    output logic            empty,
    output logic            full,
    output logic            overflow
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WDTH-1:0]      mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_reg;
    logic [LOG_DEPTH-1:0] rd_ptr_reg;
    logic [LOG_DEPTH:0]   count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (LOG_DEPTH+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign data_out = mem[rd_ptr_reg];

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/message_stream_combiner.sv
// Merges per-stage debug message streams into one word stream, forwarding
// whole packets (header + L payload words) under round-robin arbitration.
module message_stream_combiner
    import message_stream_combiner_pkg::*;
#(
    parameter int N_STREAMS         = 2,
    parameter int WDTH              = 32,
    parameter int LOG_BUFFER_LENGTH = 4,
    parameter int LEN_WDTH          = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_STREAMS*WDTH-1:0] in_data,
    input  logic [N_STREAMS-1:0]      in_nd,
    output logic [WDTH-1:0]           out_data,
    output logic                      out_nd,
    output logic [2:0]                out_stream,
    output logic                      error
);

    localparam int LEN_MSB = msg_len_msb(WDTH);
    localparam int LEN_LSB = msg_len_lsb(WDTH, LEN_WDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [MAX_STREAMS-1:0] empty_pad;
    logic [MAX_STREAMS-1:0] ovf_pad;
    logic [WDTH-1:0]        dout_pad [MAX_STREAMS];

    logic [0:0]          state_reg, state_next;
    stream_idx_t         rr_ptr_reg, rr_ptr_next;
    stream_idx_t         lock_reg, lock_next;
    logic [LEN_WDTH-1:0] remaining_reg, remaining_next;
    logic [WDTH-1:0]     out_data_reg, out_data_next;
    logic                out_nd_reg, out_nd_next;
    stream_idx_t         out_stream_reg, out_stream_next;
    logic                error_reg, error_next;

    logic                found;
    stream_idx_t         search_sel;
    stream_idx_t         cand;
    logic                pop_any;
    stream_idx_t         pop_sel;
    logic [LEN_WDTH-1:0] hdr_len;

    // Unused slots up to MAX_STREAMS read as permanently empty.
    generate
        for (genvar gi = 0; gi < MAX_STREAMS; gi++) begin : g_stream
            if (gi < N_STREAMS) begin : g_fifo
                logic fifo_full;
                msg_fifo #(
                    .WDTH      (WDTH),
                    .LOG_DEPTH (LOG_BUFFER_LENGTH)
                ) u_fifo (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .push     (in_nd[gi]),
                    .pop      (pop_any && (pop_sel == stream_idx_t'(gi))),
                    .data_in  (in_data[gi*WDTH +: WDTH]),
                    .data_out (dout_pad[gi]),
                    .empty    (empty_pad[gi]),
                    .full     (fifo_full),
                    .overflow (ovf_pad[gi])
                );
            end else begin : g_unused
                assign empty_pad[gi] = 1'b1;
                assign ovf_pad[gi]   = 1'b0;
                assign dout_pad[gi]  = '0;
            end
        end
    endgenerate

    always_comb begin
        found      = 1'b0;
        search_sel = '0;
        cand       = rr_ptr_reg;
        for (int o = 0; o < N_STREAMS; o++) begin
            if (!found && !empty_pad[cand]) begin
                found      = 1'b1;
                search_sel = cand;
            end
            cand = rr_next(cand, N_STREAMS);
        end

        pop_any         = 1'b0;
        pop_sel         = lock_reg;
        hdr_len         = '0;
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        lock_next       = lock_reg;
        remaining_next  = remaining_reg;
        out_data_next   = out_data_reg;
        out_nd_next     = 1'b0;
        out_stream_next = out_stream_reg;
        error_next      = error_reg | (|ovf_pad);

        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    pop_any        = 1'b1;
                    pop_sel        = search_sel;
                    hdr_len        = dout_pad[search_sel][LEN_MSB:LEN_LSB];
                    remaining_next = hdr_len;
                    lock_next      = search_sel;
                    rr_ptr_next    = rr_next(search_sel, N_STREAMS);
                    state_next     = (hdr_len != '0) ? ST_BODY : ST_IDLE;
                end
            end
            default: begin
                if (!empty_pad[lock_reg]) begin
                    pop_any        = 1'b1;
                    remaining_next = remaining_reg - LEN_WDTH'(1);
                    if (remaining_reg == LEN_WDTH'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase

        if (pop_any) begin
            out_data_next   = dout_pad[pop_sel];
            out_nd_next     = 1'b1;
            out_stream_next = pop_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            lock_reg       <= '0;
            remaining_reg  <= '0;
            out_data_reg   <= '0;
            out_nd_reg     <= 1'b0;
            out_stream_reg <= '0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            lock_reg       <= lock_next;
            remaining_reg  <= remaining_next;
            out_data_reg   <= out_data_next;
            out_nd_reg     <= out_nd_next;
            out_stream_reg <= out_stream_next;
            error_reg      <= error_next;
        end
    end

    assign out_data   = out_data_reg;
    assign out_nd     = out_nd_reg;
    assign out_stream = out_stream_reg;
    assign error      = error_reg;

endmodule

// File: tb/tb_message_stream_combiner.sv
// Scoreboard bench for message_stream_combiner: per-stream expected word
// queues, a packet-level monitor, directed scenarios and a random phase.
module tb_message_stream_combiner;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int LB = 4;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_nd;
    logic [W-1:0]  out_data;
    logic          out_nd;
    logic [2:0]    out_stream;
    logic          error;

    logic [W-1:0]  drv_data [N] = '{32'h0, 32'h0};
    logic          drv_nd   [N] = '{1'b0, 1'b0};

    assign in_data = {drv_data[1], drv_data[0]};
    assign in_nd   = {drv_nd[1], drv_nd[0]};

    message_stream_combiner #(
        .N_STREAMS         (N),
        .WDTH              (W),
        .LOG_BUFFER_LENGTH (LB),
        .LEN_WDTH          (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_nd      (in_nd),
        .out_data   (out_data),
        .out_nd     (out_nd),
        .out_stream (out_stream),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q [N][$];
    int hdr_stream_q [$];
    int hdr_cyc_q [$];
    int mon_rem = 0;
    int mon_lock = 0;
    int mon_s;
    logic [W-1:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every output word must be the next word queued for its stream,
    // and payload words must stay on the stream that sent the header.
    always @(negedge clk) begin
        if (rst_n && out_nd) begin
            mon_s = int'(out_stream);
            $display("out stream=%0d data=%08h cyc=%0d", mon_s, out_data, cyc);
            if (mon_s >= N) begin
                chk("out_stream_range", 64'(mon_s), 64'(0));
            end else if (exp_q[mon_s].size() == 0) begin
                chk("unexpected_word_queue_size", 64'(0), 64'(1));
            end else begin
                mon_exp = exp_q[mon_s].pop_front();
                chk("out_data", out_data, mon_exp);
                if (mon_rem == 0) begin
                    hdr_stream_q.push_back(mon_s);
                    hdr_cyc_q.push_back(cyc);
                    mon_rem  = int'(mon_exp[30:21]);
                    mon_lock = mon_s;
                end else begin
                    chk("packet_contiguity", 64'(mon_s), 64'(mon_lock));
                    mon_rem--;
                end
            end
        end
    end

    task automatic clear_model();
        for (int s = 0; s < N; s++) exp_q[s].delete();
        hdr_stream_q.delete();
        hdr_cyc_q.delete();
        mon_rem = 0;
    endtask

    task automatic cyc_drive(input bit nd0, input logic [W-1:0] w0, input bit k0,
                             input bit nd1, input logic [W-1:0] w1, input bit k1);
        drv_nd[0] = nd0; drv_data[0] = w0;
        drv_nd[1] = nd1; drv_data[1] = w1;
        if (nd0 && k0) exp_q[0].push_back(w0);
        if (nd1 && k1) exp_q[1].push_back(w1);
        @(negedge clk);
        drv_nd[0] = 1'b0;
        drv_nd[1] = 1'b0;
    endtask

    task automatic send0(input logic [W-1:0] w);
        cyc_drive(1'b1, w, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic send1(input logic [W-1:0] w);
        cyc_drive(1'b0, '0, 1'b0, 1'b1, w, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drv_nd[0] = 1'b0;
        drv_nd[1] = 1'b0;
        clear_model();
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && (exp_q[0].size() + exp_q[1].size()) != 0; i++)
            @(negedge clk);
        idle(2);
        chk(name, 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));
    endtask

    task automatic send_one(input int s, input logic [W-1:0] w);
        while (exp_q[s].size() >= 12) @(negedge clk);
        drv_data[s] = w;
        drv_nd[s]   = 1'b1;
        exp_q[s].push_back(w);
        @(negedge clk);
        drv_nd[s] = 1'b0;
        if ($urandom_range(0, 2) == 0) @(negedge clk);
    endtask

    task automatic rand_driver(input int s, input int npkts);
        logic [W-1:0] hdr;
        logic [9:0]   len;
        for (int p = 0; p < npkts; p++) begin
            len = 10'($urandom_range(0, 5));
            hdr = $urandom;
            hdr[30:21] = len;
            send_one(s, hdr);
            for (int j = 0; j < int'(len); j++) send_one(s, $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int exp_rr [4];
        exp_rr = '{0, 1, 0, 0};

        // Reset state while rst_n is held low
        #1;
        chk("rst_out_nd", 64'(out_nd), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_stream", 64'(out_stream), 64'(0));
        chk("rst_error", 64'(error), 64'(0));

        // Length-1 packet, latency
        do_reset();
        d = cyc;
        send0(32'h0020_0000);
        send0(32'hDEAD_BEEF);
        drain("t1_drain", 50);
        chk("t1_hdr_count", 64'(hdr_stream_q.size()), 64'(1));
        if (hdr_stream_q.size() == 1) begin
            chk("t1_stream", 64'(hdr_stream_q[0]), 64'(0));
            chk("t1_latency", 64'(hdr_cyc_q[0] - d), 64'(2));
        end
        chk("t1_error", 64'(error), 64'(0));

        // Simultaneous L=2 packets
        do_reset();
        cyc_drive(1'b1, 32'h0040_0011, 1'b1, 1'b1, 32'h0040_0022, 1'b1);
        cyc_drive(1'b1, 32'hA000_0001, 1'b1, 1'b1, 32'hB000_0001, 1'b1);
        cyc_drive(1'b1, 32'hA000_0002, 1'b1, 1'b1, 32'hB000_0002, 1'b1);
        drain("t2_drain", 50);
        chk("t2_hdr_count", 64'(hdr_stream_q.size()), 64'(2));
        if (hdr_stream_q.size() == 2) begin
            chk("t2_first", 64'(hdr_stream_q[0]), 64'(0));
            chk("t2_second", 64'(hdr_stream_q[1]), 64'(1));
            chk("t2_no_gap", 64'(hdr_cyc_q[1] - hdr_cyc_q[0]), 64'(3));
        end

        // Round robin of zero-length packets
        do_reset();
        cyc_drive(1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0001, 1'b1);
        send0(32'h0000_0000);
        send0(32'h0000_0000);
        drain("t3_drain", 50);
        chk("t3_hdr_count", 64'(hdr_stream_q.size()), 64'(4));
        if (hdr_stream_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_rr_order", 64'(hdr_stream_q[i]), 64'(exp_rr[i]));

        // Stall mid-packet
        do_reset();
        send1(32'h0060_0100);
        send0(32'h0020_0005);
        send0(32'h1111_1111);
        idle(1);
        send1(32'h2222_0001);
        idle(3);
        send1(32'h2222_0002);
        idle(3);
        send1(32'h2222_0003);
        drain("t4_drain", 50);
        chk("t4_hdr_count", 64'(hdr_stream_q.size()), 64'(2));
        if (hdr_stream_q.size() == 2) begin
            chk("t4_first", 64'(hdr_stream_q[0]), 64'(1));
            chk("t4_second", 64'(hdr_stream_q[1]), 64'(0));
            chk("t4_gap", 64'(hdr_cyc_q[1] - hdr_cyc_q[0]), 64'(13));
        end

        // Overflow while stream0 is locked awaiting payload
        do_reset();
        send0(32'h0020_0000);
        idle(3);
        for (int i = 0; i < 17; i++)
            cyc_drive(1'b0, '0, 1'b0, 1'b1, (i == 0) ? 32'h01E0_0000 : $urandom, i < 16);
        idle(2);
        chk("t5_error_set", 64'(error), 64'(1));
        send0(32'hCAFE_F00D);
        drain("t5_drain", 80);
        chk("t5_error_sticky", 64'(error), 64'(1));
        chk("t5_hdr_count", 64'(hdr_stream_q.size()), 64'(2));

        // Reset in the middle of an L=4 packet on stream1
        send1(32'h0080_0000);
        send1(32'h3333_0001);
        send1(32'h3333_0002);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_nd", 64'(out_nd), 64'(0));
        chk("t6_out_data", 64'(out_data), 64'(0));
        chk("t6_out_stream", 64'(out_stream), 64'(0));
        chk("t6_error", 64'(error), 64'(0));
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send0(32'h0020_0000);
        send0(32'h4444_4444);
        drain("t6_drain", 50);
        chk("t6_hdr_count", 64'(hdr_stream_q.size()), 64'(1));

        // Randomized traffic on both streams
        do_reset();
        fork
            rand_driver(0, 20);
            rand_driver(1, 20);
        join
        drain("t7_drain", 2000);
        chk("t7_error", 64'(error), 64'(0));
        chk("t7_hdr_count", 64'(hdr_stream_q.size()), 64'(40));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
